// File: rtl/forward_bypass_buf.sv
// Operand forwarding network for the EX stage. It selects each source operand from
// MEM, WB, a short history of retired writes, or the register file. It also flags
// load-use hazards and counts the cycles spent stalled on them.
module forward_bypass_buf #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned HIST_DEPTH = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              advance,
  input  logic                              mem_load_regfile,
  input  logic                              mem_is_load,
  input  logic [4:0]                        mem_rd_num,
  input  logic [XLEN-1:0]                   mem_rd_data,
  input  logic                              wb_load_regfile,
  input  logic [4:0]                        wb_rd_num,
  input  logic [XLEN-1:0]                   wb_rd_data,
  input  logic [NUM_SRC-1:0][4:0]           ex_rs_num,
  input  logic [NUM_SRC-1:0]                ex_rs_used,
  input  logic [NUM_SRC-1:0][XLEN-1:0]      ex_rs_data,
  output logic [NUM_SRC-1:0][XLEN-1:0]      fwd_data,
  output logic [NUM_SRC-1:0][2:0]           fwd_sel,
  output logic                              load_use_stall,
  output logic [CNT_W-1:0]                  lu_stall_count
);

  // Keep the storage arrays legal when the history is disabled; they are tied off below.
  localparam int unsigned HistSlots = (HIST_DEPTH == 0) ? 1 : HIST_DEPTH;

  logic [HistSlots-1:0]           hist_valid_q;
  logic [HistSlots-1:0][4:0]      hist_num_q;
  logic [HistSlots-1:0][XLEN-1:0] hist_data_q;
  logic [CNT_W-1:0]               cnt_q;
  logic [CNT_W-1:0]               cnt_d;

  if (HIST_DEPTH > 0) begin : g_hist
    // Shift the retired WB write into entry 0 on every pipeline advance.
    // Only the valid bits clear on reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        hist_valid_q <= '0;
      end else if (advance) begin
        for (int k = int'(HistSlots) - 1; k > 0; k--) begin
          hist_valid_q[k] <= hist_valid_q[k-1];
          hist_num_q[k]   <= hist_num_q[k-1];
          hist_data_q[k]  <= hist_data_q[k-1];
        end
        hist_valid_q[0] <= wb_load_regfile && (wb_rd_num != 5'd0);
        hist_num_q[0]   <= wb_rd_num;
        hist_data_q[0]  <= wb_rd_data;
      end
    end
  end else begin : g_no_hist
    assign hist_valid_q = '0;
    assign hist_num_q   = '0;
    assign hist_data_q  = '0;
  end

  // Per-operand priority select: MEM, WB, newest-to-oldest history, then regfile.
  always_comb begin
    load_use_stall = 1'b0;
    fwd_data       = ex_rs_data;
    fwd_sel        = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (ex_rs_used[i] && (ex_rs_num[i] != 5'd0)) begin
        if (mem_load_regfile && (mem_rd_num == ex_rs_num[i])) begin
          // A pending load blocks every lower-priority source; the regfile value passes through.
          if (mem_is_load) begin
            load_use_stall = 1'b1;
          end else begin
            fwd_data[i] = mem_rd_data;
            fwd_sel[i]  = 3'd1;
          end
        end else if (wb_load_regfile && (wb_rd_num == ex_rs_num[i])) begin
          fwd_data[i] = wb_rd_data;
          fwd_sel[i]  = 3'd2;
        end else begin
          // Walk oldest to newest so the newest matching entry is the last one assigned.
          for (int k = int'(HIST_DEPTH) - 1; k >= 0; k--) begin
            if (hist_valid_q[k] && (hist_num_q[k] == ex_rs_num[i])) begin
              fwd_data[i] = hist_data_q[k];
              fwd_sel[i]  = 3'(3 + k);
            end
          end
        end
      end
    end
  end

  // Saturating increment while stalled.
  always_comb begin
    cnt_d = cnt_q;
    if (load_use_stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Stall counter register; reset wins over any increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign lu_stall_count = cnt_q;

endmodule

// File: tb/tb_forward_bypass_buf.sv
// Randomized and directed check of forward_bypass_buf against a queue-based model.
module tb_forward_bypass_buf;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned NUM_SRC    = 2;
  localparam int unsigned HIST_DEPTH = 2;
  localparam int unsigned CNT_W      = 4;
  localparam int          CntMax     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                         rst;
  logic                         advance;
  logic                         mem_load_regfile;
  logic                         mem_is_load;
  logic [4:0]                   mem_rd_num;
  logic [XLEN-1:0]              mem_rd_data;
  logic                         wb_load_regfile;
  logic [4:0]                   wb_rd_num;
  logic [XLEN-1:0]              wb_rd_data;
  logic [NUM_SRC-1:0][4:0]      ex_rs_num;
  logic [NUM_SRC-1:0]           ex_rs_used;
  logic [NUM_SRC-1:0][XLEN-1:0] ex_rs_data;
  logic [NUM_SRC-1:0][XLEN-1:0] fwd_data;
  logic [NUM_SRC-1:0][2:0]      fwd_sel;
  logic                         load_use_stall;
  logic [CNT_W-1:0]             lu_stall_count;

  forward_bypass_buf #(
    .XLEN      (XLEN),
    .NUM_SRC   (NUM_SRC),
    .HIST_DEPTH(HIST_DEPTH),
    .CNT_W     (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .advance         (advance),
    .mem_load_regfile(mem_load_regfile),
    .mem_is_load     (mem_is_load),
    .mem_rd_num      (mem_rd_num),
    .mem_rd_data     (mem_rd_data),
    .wb_load_regfile (wb_load_regfile),
    .wb_rd_num       (wb_rd_num),
    .wb_rd_data      (wb_rd_data),
    .ex_rs_num       (ex_rs_num),
    .ex_rs_used      (ex_rs_used),
    .ex_rs_data      (ex_rs_data),
    .fwd_data        (fwd_data),
    .fwd_sel         (fwd_sel),
    .load_use_stall  (load_use_stall),
    .lu_stall_count  (lu_stall_count)
  );

  // Model: list of retired writes, newest first; an empty slot counts as invalid.
  typedef struct {
    bit              valid;
    logic [4:0]      num;
    logic [XLEN-1:0] data;
  } wr_t;

  wr_t hist[$];
  int  cnt_model;
  int  total;
  int  bad;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void ref_operand(input int i, output logic [XLEN-1:0] d, output int sel,
                                      output bit hazard);
    d      = ex_rs_data[i];
    sel    = 0;
    hazard = 1'b0;
    if (!ex_rs_used[i] || ex_rs_num[i] == 5'd0) return;
    if (mem_load_regfile && mem_rd_num == ex_rs_num[i]) begin
      if (mem_is_load) hazard = 1'b1;
      else begin
        d   = mem_rd_data;
        sel = 1;
      end
      return;
    end
    if (wb_load_regfile && wb_rd_num == ex_rs_num[i]) begin
      d   = wb_rd_data;
      sel = 2;
      return;
    end
    foreach (hist[k]) begin
      if (hist[k].valid && hist[k].num == ex_rs_num[i]) begin
        d   = hist[k].data;
        sel = 3 + k;
        return;
      end
    end
  endfunction

  function automatic bit exp_stall();
    logic [XLEN-1:0] d;
    int              sel;
    bit              hz;
    bit              any = 1'b0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      ref_operand(i, d, sel, hz);
      any |= hz;
    end
    return any;
  endfunction

  task automatic check_outputs();
    logic [XLEN-1:0] d;
    int              sel;
    bit              hz;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      ref_operand(i, d, sel, hz);
      check($sformatf("fwd_data[%0d]", i), 64'(fwd_data[i]), 64'(d));
      check($sformatf("fwd_sel[%0d]", i), 64'(fwd_sel[i]), 64'(sel));
    end
    check("load_use_stall", 64'(load_use_stall), 64'(exp_stall()));
    check("lu_stall_count", 64'(lu_stall_count), 64'(cnt_model));
  endtask

  function automatic void update_model();
    bit  st = exp_stall();
    wr_t e;
    if (rst) begin
      hist.delete();
      cnt_model = 0;
    end else begin
      if (st && cnt_model < CntMax) cnt_model++;
      if (advance) begin
        e.valid = wb_load_regfile && (wb_rd_num != 5'd0);
        e.num   = wb_rd_num;
        e.data  = wb_rd_data;
        hist.push_front(e);
        while (hist.size() > HIST_DEPTH) void'(hist.pop_back());
      end
    end
  endfunction

  // One cycle: check outputs mid-cycle, then mirror the clock edge in the model.
  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic idle();
    rst              = 1'b0;
    advance          = 1'b0;
    mem_load_regfile = 1'b0;
    mem_is_load      = 1'b0;
    mem_rd_num       = 5'd0;
    mem_rd_data      = '0;
    wb_load_regfile  = 1'b0;
    wb_rd_num        = 5'd0;
    wb_rd_data       = '0;
    ex_rs_num        = '0;
    ex_rs_used       = '0;
    ex_rs_data       = {32'h0000_bbbb, 32'h0000_aaaa};
  endtask

  task automatic randomize_inputs();
    rst              = ($urandom_range(0, 99) == 0);
    advance          = ($urandom_range(0, 3) != 0);
    mem_load_regfile = ($urandom_range(0, 1) == 1);
    mem_is_load      = ($urandom_range(0, 3) == 0);
    mem_rd_num       = 5'($urandom_range(0, 7));
    mem_rd_data      = $urandom;
    wb_load_regfile  = ($urandom_range(0, 1) == 1);
    wb_rd_num        = 5'($urandom_range(0, 7));
    wb_rd_data       = $urandom;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      ex_rs_num[i]  = 5'($urandom_range(0, 7));
      ex_rs_used[i] = ($urandom_range(0, 4) != 0);
      ex_rs_data[i] = $urandom;
    end
  endtask

  logic [CNT_W-1:0] cnt_before;

  initial begin
    total     = 0;
    bad       = 0;
    cnt_model = 0;
    idle();
    rst = 1'b1;
    @(posedge clk);
    update_model();
    #1;
    // Outputs with reset still asserted use the cleared history.
    step();
    rst = 1'b0;
    step();
    check("reset_count", 64'(lu_stall_count), 64'd0);

    // MEM beats WB for the same register.
    idle();
    mem_load_regfile = 1'b1; mem_rd_num = 5'd5; mem_rd_data = 32'h11;
    wb_load_regfile  = 1'b1; wb_rd_num  = 5'd5; wb_rd_data  = 32'h22;
    ex_rs_num[0] = 5'd5; ex_rs_used[0] = 1'b1;
    #1;
    check("mem_over_wb_data", 64'(fwd_data[0]), 64'h11);
    check("mem_over_wb_sel", 64'(fwd_sel[0]), 64'd1);
    step();

    // Retired WB write is visible from history entry 0.
    idle();
    wb_load_regfile = 1'b1; wb_rd_num = 5'd7; wb_rd_data = 32'hABCD; advance = 1'b1;
    step();
    idle();
    ex_rs_num[1] = 5'd7; ex_rs_used[1] = 1'b1;
    #1;
    check("hist0_data", 64'(fwd_data[1]), 64'hABCD);
    check("hist0_sel", 64'(fwd_sel[1]), 64'd3);
    step();

    // History holds through stalls, then ages out.
    idle();
    wb_load_regfile = 1'b1; wb_rd_num = 5'd7; wb_rd_data = 32'h1234; advance = 1'b1;
    step();
    idle();
    ex_rs_num[1] = 5'd7; ex_rs_used[1] = 1'b1;
    repeat (3) step();
    check("hold_sel", 64'(fwd_sel[1]), 64'd3);
    check("hold_data", 64'(fwd_data[1]), 64'h1234);
    advance = 1'b1;
    repeat (HIST_DEPTH + 1) step();
    check("aged_out_sel", 64'(fwd_sel[1]), 64'd0);

    // Load-use hazard blocks WB fallthrough; unused operand does not stall.
    idle();
    mem_load_regfile = 1'b1; mem_is_load = 1'b1; mem_rd_num = 5'd3;
    wb_load_regfile  = 1'b1; wb_rd_num   = 5'd3; wb_rd_data = 32'h99;
    ex_rs_num[0] = 5'd3; ex_rs_used[0] = 1'b1;
    #1;
    check("lu_stall", 64'(load_use_stall), 64'd1);
    check("lu_sel", 64'(fwd_sel[0]), 64'd0);
    check("lu_data", 64'(fwd_data[0]), 64'h0000_aaaa);
    cnt_before = lu_stall_count;
    step();
    check("lu_count_inc", 64'(lu_stall_count), 64'(cnt_before) + 64'd1);
    ex_rs_used[0] = 1'b0;
    #1;
    check("lu_unused", 64'(load_use_stall), 64'd0);
    step();

    // x0 is never forwarded.
    idle();
    mem_load_regfile = 1'b1; mem_rd_num = 5'd0; mem_rd_data = 32'h55;
    wb_load_regfile  = 1'b1; wb_rd_num  = 5'd0; wb_rd_data  = 32'h66;
    ex_rs_used = '1;
    #1;
    check("x0_sel", 64'(fwd_sel[0]), 64'd0);
    check("x0_data", 64'(fwd_data[0]), 64'h0000_aaaa);
    step();

    // Held hazard saturates the counter; reset clears it and the history.
    idle();
    mem_load_regfile = 1'b1; mem_is_load = 1'b1; mem_rd_num = 5'd3;
    ex_rs_num[0] = 5'd3; ex_rs_used[0] = 1'b1;
    wb_load_regfile = 1'b1; wb_rd_num = 5'd9; wb_rd_data = 32'h77; advance = 1'b1;
    repeat (20) step();
    check("cnt_saturated", 64'(lu_stall_count), 64'(CntMax));
    rst = 1'b1;
    step();
    idle();
    ex_rs_num[1] = 5'd9; ex_rs_used[1] = 1'b1;
    #1;
    check("rst_count", 64'(lu_stall_count), 64'd0);
    check("rst_hist_empty", 64'(fwd_sel[1]), 64'd0);
    step();

    for (int n = 0; n < 3000; n++) begin
      randomize_inputs();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
